// File: rtl/cmp_arbiter.sv
// Round-robin front end sharing one signed comparator among NREQ requesters.
// Define CMP_ARB_SELFCHECK_EN to add a sticky reference check on the flags.
module cmp_arbiter #(
  parameter  int NREQ = 2,
  parameter  int W    = 16,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*2-1:0] req_cond,
  output logic [W-1:0]      cmp_a,
  output logic [W-1:0]      cmp_b,
  input  logic              cmp_eq,
  input  logic              cmp_neq,
  input  logic              cmp_geq,
  input  logic              cmp_l,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IW-1:0]     resp_id,
  output logic              resp_result,
  output logic [3:0]        resp_flags,
  output logic              err_mismatch
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   gnt;
  logic            found;
  logic [NREQ-1:0] rot;
  int              sum;
  logic [W-1:0]    a_q, b_q, a_sel, b_sel;
  logic [1:0]      cond_q, c_sel;
  logic [IW-1:0]   id_q;
  logic [3:0]      flags;
  logic            sel;

  assign flags = {cmp_eq, cmp_neq, cmp_geq, cmp_l};
  assign cmp_a = a_q;
  assign cmp_b = b_q;

  // rotate so bit 0 is the requester at ptr, first set bit wins
  always_comb begin
    rot   = NREQ'({req_valid, req_valid} >> ptr_q);
    found = 1'b0;
    gnt   = '0;
    sum   = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = int'(ptr_q) + k;
        if (sum >= NREQ) sum = sum - NREQ;
        gnt   = IW'(sum);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    c_sel     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt == IW'(k)) begin
        req_ready[k] = found && (state_q == IDLE);
        a_sel        = req_a[k*W +: W];
        b_sel        = req_b[k*W +: W];
        c_sel        = req_cond[k*2 +: 2];
      end
    end
  end

  always_comb begin
    sel = 1'b0;
    unique case (1'b1)
      cond_q == 2'b00: sel = flags[3];
      cond_q == 2'b01: sel = flags[2];
      cond_q == 2'b10: sel = flags[1];
      cond_q == 2'b11: sel = flags[0];
      default:         sel = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = EVAL;
      EVAL:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cond_q      <= '0;
      id_q        <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= 1'b0;
      resp_flags  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            a_q    <= a_sel;
            b_q    <= b_sel;
            cond_q <= c_sel;
            id_q   <= gnt;
          end
        end
        EVAL: begin
          resp_flags  <= flags;
          resp_result <= sel;
          resp_id     <= id_q;
          resp_valid  <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            ptr_q      <= (id_q == IW'(NREQ-1)) ?
                          '0 : id_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CMP_ARB_SELFCHECK_EN
  logic [3:0] ref_flags;
  logic       err_q;

  always_comb begin
    ref_flags = {a_q == b_q,
                 a_q != b_q,
                 $signed(a_q) >= $signed(b_q),
                 $signed(a_q) <  $signed(b_q)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (state_q == EVAL && ref_flags != flags)
      err_q <= 1'b1;
  end

  assign err_mismatch = err_q;
`else
  assign err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter with a behavioural comparator model.
// Arbitration and responses are checked by two decoupled monitors.
module tb_cmp_arbiter;
  localparam int N = 2;
  localparam int W = 16;
`ifdef CMP_ARB_SELFCHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N*2-1:0] req_cond;
  logic [W-1:0]   cmp_a, cmp_b;
  logic           cmp_eq, cmp_neq, cmp_geq, cmp_l;
  logic           resp_valid, resp_ready;
  logic [0:0]     resp_id;
  logic           resp_result;
  logic [3:0]     resp_flags;
  logic           err_mismatch;

  always #5 clk = ~clk;

  cmp_arbiter #(.NREQ(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cond(req_cond),
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_eq(cmp_eq), .cmp_neq(cmp_neq),
    .cmp_geq(cmp_geq), .cmp_l(cmp_l),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result),
    .resp_flags(resp_flags), .err_mismatch(err_mismatch)
  );

  typedef struct {
    int         id;
    logic       res;
    logic [3:0] fl;
    bit         bad;
  } exp_t;

  logic         rv[N];
  logic [W-1:0] ra[N], rb[N];
  logic [1:0]   rc[N];
  bit           taken[N];
  bit           inj = 1'b0;

  exp_t         q[$];
  int           gnt_log[$];
  int           acc_log[$];
  int           m_ptr = 0;
  bit           busy = 1'b0;
  int           acc_cyc = 0;
  logic [W-1:0] last_a = '0, last_b = '0;
  bit           err_exp = 1'b0;
  bit           in_rst = 1'b1;
  int           cyc = 0;
  int           n_chk = 0, n_bad = 0;

  int           a_w, a_j;
  logic [3:0]   a_fl;
  logic [N-1:0] a_er;
  bit           m_ev;

  always_comb begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cond  = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = rv[i];
      req_a[i*W +: W]    = ra[i];
      req_b[i*W +: W]    = rb[i];
      req_cond[i*2 +: 2] = rc[i];
    end
  end

  // comparator model, optionally lying about eq for 0001 vs FFFF
  function automatic logic [3:0] cmp_model(
    logic [W-1:0] a, logic [W-1:0] b, bit f);
    logic eq;
    eq = (a == b) || (f && a == 16'h0001 && b == 16'hFFFF);
    return {eq, a != b,
            $signed(a) >= $signed(b),
            $signed(a) <  $signed(b)};
  endfunction

  function automatic logic pick(logic [3:0] f, logic [1:0] c);
    case (c)
      2'b00:   return f[3];
      2'b01:   return f[2];
      2'b10:   return f[1];
      default: return f[0];
    endcase
  endfunction

  always_comb begin
    {cmp_eq, cmp_neq, cmp_geq, cmp_l} = cmp_model(cmp_a, cmp_b, inj);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(string nm);
    n_chk++;
    n_bad++;
    $display("FAIL %s: timed out t=%0t", nm, $time);
  endtask

  // arbitration model: round-robin from the last served requester
  always @(negedge clk) begin
    if (!in_rst) begin
      a_w = -1;
      if (!busy) begin
        for (int k = 0; k < N; k++) begin
          a_j = (m_ptr + k) % N;
          if (a_w < 0 && rv[a_j]) a_w = a_j;
        end
      end
      a_er = '0;
      if (a_w >= 0) a_er = N'(1) << a_w;
      chk("req_ready", 32'(req_ready), 32'(a_er));
      chk("cmp_a", 32'(cmp_a), 32'(last_a));
      chk("cmp_b", 32'(cmp_b), 32'(last_b));
      if (a_w >= 0) begin
        a_fl = cmp_model(ra[a_w], rb[a_w], inj);
        q.push_back('{a_w, pick(a_fl, rc[a_w]), a_fl,
                      a_fl != cmp_model(ra[a_w], rb[a_w], 1'b0)});
        busy     = 1'b1;
        acc_cyc  = cyc;
        last_a   = ra[a_w];
        last_b   = rb[a_w];
        taken[a_w] = 1'b1;
        gnt_log.push_back(a_w);
        acc_log.push_back(cyc);
      end
    end
  end

  // response monitor: pops the scoreboard on each completed handshake
  always @(negedge clk) begin
    #1;
    if (!in_rst) begin
      m_ev = busy && (cyc >= acc_cyc + 2);
      if (SC && m_ev && cyc == acc_cyc + 2 && q.size() > 0 && q[0].bad)
        err_exp = 1'b1;
      chk("resp_valid", 32'(resp_valid), 32'(m_ev));
      chk("err_mismatch", 32'(err_mismatch), 32'(err_exp));
      if (m_ev && resp_valid && q.size() > 0) begin
        chk("resp_id", 32'(resp_id), 32'(q[0].id));
        chk("resp_result", 32'(resp_result), 32'(q[0].res));
        chk("resp_flags", 32'(resp_flags), 32'(q[0].fl));
        if (resp_ready) begin
          m_ptr = (q[0].id + 1) % N;
          void'(q.pop_front());
          busy = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(int i, logic [W-1:0] a, logic [W-1:0] b,
                     logic [1:0] c);
    rv[i]    = 1'b1;
    ra[i]    = a;
    rb[i]    = b;
    rc[i]    = c;
    taken[i] = 1'b0;
  endtask

  task automatic wait_taken(int i);
    int t = 0;
    while (!taken[i] && t < 50) begin
      tick();
      t++;
    end
    if (!taken[i]) timeout("wait_taken");
    rv[i]    = 1'b0;
    taken[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 60) begin
      tick();
      t++;
    end
    if (busy) timeout("wait_idle");
  endtask

  task automatic quiesce();
    for (int i = 0; i < N; i++) begin
      rv[i]    = 1'b0;
      taken[i] = 1'b0;
    end
    resp_ready = 1'b1;
    wait_idle();
  endtask

  task automatic expect_resp(int id, logic res, logic [3:0] fl);
    int t = 0;
    while (!resp_valid && t < 10) begin
      tick();
      t++;
    end
    if (!resp_valid) timeout("expect_resp");
    chk("dir id", 32'(resp_id), 32'(id));
    chk("dir result", 32'(resp_result), 32'(res));
    chk("dir flags", 32'(resp_flags), 32'(fl));
    wait_idle();
  endtask

  task automatic chk_zero(string nm);
    chk({nm, " req_ready"}, 32'(req_ready), 0);
    chk({nm, " cmp_a"}, 32'(cmp_a), 0);
    chk({nm, " cmp_b"}, 32'(cmp_b), 0);
    chk({nm, " resp_valid"}, 32'(resp_valid), 0);
    chk({nm, " resp_id"}, 32'(resp_id), 0);
    chk({nm, " resp_result"}, 32'(resp_result), 0);
    chk({nm, " resp_flags"}, 32'(resp_flags), 0);
    chk({nm, " err"}, 32'(err_mismatch), 0);
  endtask

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(6))
      0:       return 16'h0000;
      1:       return 16'h0001;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      4:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic run(int n, bit cont, bit bp);
    logic [W-1:0] a;
    for (int c = 0; c < n; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (taken[i]) begin
          taken[i] = 1'b0;
          rv[i]    = 1'b0;
        end
        if (!rv[i] && (cont || $urandom_range(3) == 0)) begin
          a = rnd();
          put(i, a, ($urandom_range(3) == 0) ? a : rnd(),
              2'($urandom_range(3)));
        end else if (rv[i] && !cont && $urandom_range(15) == 0) begin
          rv[i] = 1'b0;
        end
      end
      resp_ready = bp ? ($urandom_range(2) != 0) : 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b1;
    resp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      rv[i]    = 1'b0;
      ra[i]    = '0;
      rb[i]    = '0;
      rc[i]    = '0;
      taken[i] = 1'b0;
    end
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n      = 1'b1;
    in_rst     = 1'b0;
    resp_ready = 1'b1;

    put(0, 16'h0005, 16'h0003, 2'b10);
    wait_taken(0);
    expect_resp(0, 1'b1, 4'b0110);

    put(1, 16'h8000, 16'h7FFF, 2'b11);
    wait_taken(1);
    expect_resp(1, 1'b1, 4'b0101);
    put(1, 16'h7FFF, 16'h8000, 2'b11);
    wait_taken(1);
    expect_resp(1, 1'b0, 4'b0110);

    gnt_log.delete();
    acc_log.delete();
    run(13, 1'b1, 1'b0);
    quiesce();
    if (gnt_log.size() < 4) begin
      timeout("fairness grants");
    end else begin
      for (int k = 0; k < 4; k++)
        chk("rr order", 32'(gnt_log[k]), 32'(k % 2));
      for (int k = 0; k < 3; k++)
        chk("rr spacing", 32'(acc_log[k+1] - acc_log[k]), 3);
    end

    resp_ready = 1'b0;
    put(0, 16'h0010, 16'h0020, 2'b11);
    wait_taken(0);
    put(1, 16'h0020, 16'h0010, 2'b01);
    for (int t = 0; t < 10 && !resp_valid; t++) tick();
    repeat (5) tick();
    chk("no accept in stall", 32'(taken[1]), 0);
    resp_ready = 1'b1;
    wait_taken(1);
    wait_idle();

    inj = 1'b1;
    put(0, 16'h0001, 16'hFFFF, 2'b00);
    wait_taken(0);
    wait_idle();
    inj = 1'b0;
    put(1, 16'h0003, 16'h0003, 2'b00);
    wait_taken(1);
    wait_idle();

    run(400, 1'b0, 1'b1);
    quiesce();

    put(0, 16'h0002, 16'h0009, 2'b11);
    wait_taken(0);
    wait_idle();
    put(1, 16'h1234, 16'h1234, 2'b00);
    wait_taken(1);
    in_rst = 1'b1;
    rst_n  = 1'b0;
    #1;
    chk_zero("midop reset");
    busy    = 1'b0;
    q.delete();
    m_ptr   = 0;
    last_a  = '0;
    last_b  = '0;
    err_exp = 1'b0;
    for (int i = 0; i < N; i++) begin
      rv[i]    = 1'b0;
      taken[i] = 1'b0;
    end
    repeat (2) tick();
    put(0, 16'h0004, 16'h0004, 2'b00);
    put(1, 16'h0004, 16'h0005, 2'b01);
    rst_n  = 1'b1;
    in_rst = 1'b0;
    tick();
    chk("tie after reset", 32'(taken[0]), 1);
    wait_taken(0);
    wait_taken(1);
    quiesce();
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares the single 16-bit two's-complement comparator between NREQ requesters, e.g. the branch unit and the set-less-than path.
- Arbitrates round-robin and registers the operands into the comparator.
- Samples the comparator flags one cycle later and returns a condition-selected result with a valid/ready response handshake.
- One request is in flight at a time. Sits between the decode/execute control and the comparator instance.

Parameters:
- NREQ, 2, number of requesters (2..8).
- W, 16, operand width; must match the comparator.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit set.
- req_a  input  NREQ*W  operand A, requester i at bits [i*W +: W].
- req_b  input  NREQ*W  operand B, same packing.
- req_cond  input  NREQ*2  condition, requester i at bits [i*2 +: 2]: 00 eq, 01 neq, 10 geq, 11 lt (signed).
- cmp_a  output  W  operand A to the comparator.
- cmp_b  output  W  operand B to the comparator.
- cmp_eq, cmp_neq, cmp_geq, cmp_l  input  1 each  comparator flags, combinational from cmp_a/cmp_b.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response consumer ready.
- resp_id  output  $clog2(NREQ) (min 1)  index of the served requester.
- resp_result  output  1  selected condition outcome.
- resp_flags  output  4  raw sampled flags {eq,neq,geq,l}.
- err_mismatch  output  1  self-check error, sticky (see Optional Feature).

Behaviour:
- Reset (async, rst_n low), all outputs and registers cleared:
  - state IDLE; req_ready=0; cmp_a=cmp_b=0; resp_valid=0; resp_id=0; resp_result=0; resp_flags=0; err_mismatch=0; rr pointer ptr=0.
  - Reset mid-operation drops the in-flight request; no response is produced.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - Winner g is the first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod NREQ.
  - req_ready is one-hot at g, combinational, and asserted only in IDLE. All zero if no valid request.
  - On edge with req_valid[g]&req_ready[g]: latch A, B, cond and g into registers. cmp_a/cmp_b take the latched operands. Next state EVAL.
- EVAL (exactly one cycle):
  - cmp_a/cmp_b held stable.
  - At the end-of-cycle edge: sample flags into resp_flags; resp_result = flag selected by cond; resp_id=g; resp_valid=1. Next state RESP.
- RESP:
  - All response outputs held stable while resp_valid=1 and resp_ready=0.
  - On edge with resp_ready=1: resp_valid=0; ptr=(g+1) mod NREQ; next state IDLE.
  - No new request is accepted in the RESP cycle, including the completing cycle.
- Latency and throughput:
  - Accept on edge k, resp_valid high after edge k+1.
  - Minimum 3 cycles per request (IDLE, EVAL, RESP), with resp_ready held high.
- Other rules:
  - cmp_a/cmp_b hold their last value in IDLE and RESP; no toggling without an accepted request.
  - req_valid deassertion while not granted is legal. Requesters must hold req_a/req_b/req_cond stable while req_valid=1.
  - resp_result uses only the sampled flags; no arithmetic is done here.

Optional Feature:
- Macro: CMP_ARB_SELFCHECK_EN.
- Defined:
  - In EVAL, compute the reference signed comparison of the latched operands internally: eq, neq, geq=(A>=B signed), l=(A<B signed).
  - On any difference from the sampled flags, err_mismatch goes 1 on the same edge that sets resp_valid. It stays 1 until reset.
  - resp_flags/resp_result still report the comparator's flags.
- Not defined: err_mismatch tied 0 and no checker logic is synthesised.

Test Plan:
- Single request: req0 A=16'h0005, B=16'h0003, cond=10. Required: req_ready[0] in the same cycle; resp_valid after 2 edges; resp_result=1, resp_flags=0110, resp_id=0.
- Signed boundary: req1 A=16'h8000, B=16'h7FFF, cond=11. Required: resp_result=1, resp_id=1. Then A=16'h7FFF, B=16'h8000, cond=11. Required: resp_result=0.
- Round-robin fairness: both requesters valid continuously with resp_ready=1. Required: grants 0,1,0,1. One response every 3 cycles; req_ready never has 2 bits set.
- Back-pressure: resp_ready=0 for 5 cycles after resp_valid. Required: outputs stable, req_ready all 0, no second accept. resp_ready=1 returns to IDLE on the next edge.
- Reset mid-op: rst_n low during EVAL of A=B=16'h1234. Required: all outputs 0 immediately; no response after release; ptr=0 (req0 wins a tie).
- CMP_ARB_SELFCHECK_EN defined, comparator model forcing eq=1 for A=16'h0001, B=16'hFFFF. Required: err_mismatch=1 with resp_valid, sticky until rst_n low. Without the macro: err_mismatch stays 0.
